// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and widths for the PE window loader
package pe_pkg;
  localparam int FILTER_WIDTH = 8;
  localparam int ROW_W = 3 * FILTER_WIDTH;
  localparam int WIN_W = 9 * FILTER_WIDTH;

  typedef enum logic {LOAD, ISSUE} loader_state_t;
  typedef logic [1:0] row_idx_t;

  localparam row_idx_t ROW_ILLEGAL = 2'd3;
endpackage

// File: rtl/pe_row_bank.sv
// rtl/pe_row_bank.sv - three-row register bank with per-row valid mask
module pe_row_bank
  import pe_pkg::*;
#(
  parameter int ROW_W = pe_pkg::ROW_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [1:0]         wr_idx,
  input  logic [ROW_W-1:0]   wr_data,
  input  logic               clear_mask,
  output logic [3*ROW_W-1:0] rows_flat,
  output logic               full
);

  logic [ROW_W-1:0] rows [3];
  logic [2:0]       mask;

  // A write in the same cycle as a clear leaves that row marked valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) rows[i] <= '0;
      mask <= '0;
    end else begin
      if (clear_mask) mask <= '0;
      if (wr_en && wr_idx != ROW_ILLEGAL) begin
        rows[wr_idx] <= wr_data;
        mask[wr_idx] <= 1'b1;
      end
    end
  end

  assign rows_flat = {rows[2], rows[1], rows[0]};
  assign full      = &mask;

endmodule

// File: rtl/pe_window_loader.sv
// rtl/pe_window_loader.sv - collects filter/ifmap rows and issues 3x3 windows
// Optional PE_LOADER_STATS_EN adds win_count/drop_count outputs.
module pe_window_loader
  import pe_pkg::*;
#(
  parameter int FILTER_WIDTH = 8,
  parameter int NUM_ROWS     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_timestep,
  input  logic                        in_ifmapb_filter,
  input  logic [1:0]                  in_filter_row,
  input  logic [3*FILTER_WIDTH-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_timestep,
  output logic [9*FILTER_WIDTH-1:0]   out_filter,
  output logic [9*FILTER_WIDTH-1:0]   out_ifmap,
`ifdef PE_LOADER_STATS_EN
  output logic [15:0]                 win_count,
  output logic [7:0]                  drop_count,
`endif
  output logic                        err_row,
  output logic                        err_ts
);

  localparam int RW = 3 * FILTER_WIDTH;

  loader_state_t state, state_next;
  logic exp_ts;
  logic filt_full, ifm_full;
  logic accept, row_legal, ts_ok, filt_wr, ifm_wr, drop, issue_done;
  logic [NUM_ROWS*RW-1:0] filt_rows, ifm_rows;

  assign accept     = in_valid && in_ready;
  assign row_legal  = in_filter_row != ROW_ILLEGAL;
  assign ts_ok      = in_timestep == exp_ts;
  assign filt_wr    = accept && row_legal && in_ifmapb_filter;
  assign ifm_wr     = accept && row_legal && !in_ifmapb_filter && ts_ok;
  assign drop       = accept && (!row_legal || (!in_ifmapb_filter && !ts_ok));
  assign issue_done = out_valid && out_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = !rst;
        if (filt_full && ifm_full) state_next = ISSUE;
      end
      ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      exp_ts  <= 1'b0;
      err_row <= 1'b0;
      err_ts  <= 1'b0;
    end else begin
      state <= state_next;
      if (issue_done) exp_ts <= ~exp_ts;
      if (accept && !row_legal) err_row <= 1'b1;
      if (accept && row_legal && !in_ifmapb_filter && !ts_ok) err_ts <= 1'b1;
    end
  end

  // Filter rows persist across windows; only the ifmap mask is cleared on issue.
  pe_row_bank #(.ROW_W(RW)) u_filt_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (filt_wr),
    .wr_idx     (in_filter_row),
    .wr_data    (in_data),
    .clear_mask (1'b0),
    .rows_flat  (filt_rows),
    .full       (filt_full)
  );

  pe_row_bank #(.ROW_W(RW)) u_ifm_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (ifm_wr),
    .wr_idx     (in_filter_row),
    .wr_data    (in_data),
    .clear_mask (issue_done),
    .rows_flat  (ifm_rows),
    .full       (ifm_full)
  );

  assign out_filter   = filt_rows;
  assign out_ifmap    = ifm_rows;
  assign out_timestep = exp_ts;

`ifdef PE_LOADER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      win_count  <= '0;
      drop_count <= '0;
    end else begin
      if (issue_done) win_count <= win_count + 16'd1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule
